// File: rtl/pipeline_controller_pkg.sv
// Shared types and constants for the 4-stage pipeline sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [1:0] MODE_IMM = 2'b00;
  localparam logic [1:0] MODE_DIR = 2'b01;
  localparam logic [1:0] MODE_REG = 2'b10;
  localparam logic [1:0] MODE_FWD = 2'b11;

  // Counter preload so that the state is held for exactly 'cycles' cycles.
  function automatic logic [3:0] cnt_init(input int unsigned cycles);
    cnt_init = 4'(cycles - 32'd1);
  endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Execute/writeback status inputs and stage-control outputs of the pipeline sequencer.
interface pipeline_controller_if #(
  parameter int unsigned REG_AW = 5
);

  logic              start;
  logic              halt_req;
  logic              store;
  logic              branch_taken;
  logic [REG_AW-1:0] src_ex;
  logic [REG_AW-1:0] dst_wb;
  logic              wb_valid;
  logic [1:0]        mode_in;
  logic [1:0]        mode_out;
  logic              pc_en;
  logic              if_id_en;
  logic              id_ex_en;
  logic              ex_wb_en;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              wea;
  logic              ram_addr_sel;
  logic              busy;

  // Controller side.
  modport master (
    input  start, halt_req, store, branch_taken, src_ex, dst_wb, wb_valid, mode_in,
    output mode_out, pc_en, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_flush,
           wea, ram_addr_sel, busy
  );

  // Datapath side.
  modport slave (
    output start, halt_req, store, branch_taken, src_ex, dst_wb, wb_valid, mode_in,
    input  mode_out, pc_en, if_id_en, id_ex_en, ex_wb_en, if_id_flush, id_ex_flush,
           wea, ram_addr_sel, busy
  );

endinterface

// File: rtl/pipeline_controller_fwd_select.sv
// B-bus mux select with writeback-to-execute forward override for register mode.
module fwd_select
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [1:0]        mode_in_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] dst_i,
  output logic [1:0]        mode_o
);

  // Only register mode can hit a pending writeback; immediate and direct pass through.
  always_comb begin
    mode_o = mode_in_i;
    if ((mode_in_i == MODE_REG) && wb_valid_i && (src_i == dst_i)) begin
      mode_o = MODE_FWD;
    end else begin
      mode_o = mode_in_i;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: stage enables/flushes, multi-cycle store hold and post-branch masking.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STORE_LAT   = 2,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned REG_AW      = 5
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_controller_if.master bus
);

  localparam logic [3:0] STALL_INIT   = cnt_init(STORE_LAT - 32'd1);
  localparam logic [3:0] FLUSH_INIT   = cnt_init(FLUSH_DEPTH);
  localparam logic       SINGLE_STORE = (STORE_LAT == 32'd1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       en_s;
  logic       flush_s;
  logic       wea_s;
  logic       sel_s;
  logic [1:0] mode_s;

  // Next-state and output decode; events are honoured only in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_s    = 1'b0;
    flush_s = 1'b0;
    wea_s   = 1'b0;
    sel_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        en_s = 1'b1;
        if (bus.branch_taken) begin
          flush_s = 1'b1;
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end else if (bus.store) begin
          wea_s = 1'b1;
          sel_s = 1'b1;
          if (SINGLE_STORE) begin
            state_d = RUN;
          end else begin
            en_s    = 1'b0;
            state_d = STALL;
            cnt_d   = STALL_INIT;
          end
        end else if (bus.halt_req) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      STALL: begin
        wea_s = 1'b1;
        sel_s = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          en_s    = 1'b1;
          state_d = RUN;
        end
      end
      FLUSH: begin
        en_s = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  fwd_select #(
    .REG_AW (REG_AW)
  ) u_fwd_select (
    .mode_in_i  (bus.mode_in),
    .wb_valid_i (bus.wb_valid),
    .src_i      (bus.src_ex),
    .dst_i      (bus.dst_wb),
    .mode_o     (mode_s)
  );

  assign bus.mode_out     = mode_s;
  assign bus.pc_en        = en_s;
  assign bus.if_id_en     = en_s;
  assign bus.id_ex_en     = en_s;
  assign bus.ex_wb_en     = en_s;
  assign bus.if_id_flush  = flush_s;
  assign bus.id_ex_flush  = flush_s;
  assign bus.wea          = wea_s;
  assign bus.ram_addr_sel = sel_s;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench: dut_a uses STORE_LAT=3/FLUSH_DEPTH=2, dut_b uses STORE_LAT=1/FLUSH_DEPTH=1.
module tb_pipeline_controller;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_controller_if #(.REG_AW(5)) bus_a ();
  pipeline_controller_if #(.REG_AW(5)) bus_b ();

  pipeline_controller #(
    .STORE_LAT   (3),
    .FLUSH_DEPTH (2),
    .REG_AW      (5)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  pipeline_controller #(
    .STORE_LAT   (1),
    .FLUSH_DEPTH (1),
    .REG_AW      (5)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] en_a();
    return {28'd0, bus_a.pc_en, bus_a.if_id_en, bus_a.id_ex_en, bus_a.ex_wb_en};
  endfunction

  function automatic logic [31:0] en_b();
    return {28'd0, bus_b.pc_en, bus_b.if_id_en, bus_b.id_ex_en, bus_b.ex_wb_en};
  endfunction

  function automatic logic [31:0] fl_a();
    return {30'd0, bus_a.if_id_flush, bus_a.id_ex_flush};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_a();
    bus_a.start = 1'b0; bus_a.halt_req = 1'b0; bus_a.store = 1'b0; bus_a.branch_taken = 1'b0;
    bus_a.src_ex = 5'd0; bus_a.dst_wb = 5'd0; bus_a.wb_valid = 1'b0; bus_a.mode_in = 2'b00;
  endtask

  task automatic clr_b();
    bus_b.start = 1'b0; bus_b.halt_req = 1'b0; bus_b.store = 1'b0; bus_b.branch_taken = 1'b0;
    bus_b.src_ex = 5'd0; bus_b.dst_wb = 5'd0; bus_b.wb_valid = 1'b0; bus_b.mode_in = 2'b00;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    clr_a();
    clr_b();
    step();
    step();
    settle();
    check_val("reset_busy", 32'(bus_a.busy), 32'd0);
    check_val("reset_en", en_a(), 32'd0);
    check_val("reset_wea", 32'(bus_a.wea), 32'd0);
    check_val("reset_flush", fl_a(), 32'd0);

    // Start pulse.
    rst_a = 1'b0;
    bus_a.start = 1'b1;
    settle();
    check_val("idle_en", en_a(), 32'd0);
    step();
    bus_a.start = 1'b0;
    settle();
    check_val("start_busy", 32'(bus_a.busy), 32'd1);
    check_val("start_en", en_a(), 32'hF);

    // Forward override.
    bus_a.mode_in = 2'b10; bus_a.wb_valid = 1'b1; bus_a.src_ex = 5'd7; bus_a.dst_wb = 5'd7;
    settle();
    check_val("fwd_reg_hit", 32'(bus_a.mode_out), 32'd3);
    bus_a.mode_in = 2'b00;
    settle();
    check_val("fwd_imm", 32'(bus_a.mode_out), 32'd0);
    bus_a.mode_in = 2'b01;
    settle();
    check_val("fwd_dir", 32'(bus_a.mode_out), 32'd1);
    bus_a.mode_in = 2'b10; bus_a.wb_valid = 1'b0;
    settle();
    check_val("fwd_no_valid", 32'(bus_a.mode_out), 32'd2);
    bus_a.wb_valid = 1'b1; bus_a.dst_wb = 5'd6;
    settle();
    check_val("fwd_diff_reg", 32'(bus_a.mode_out), 32'd2);
    clr_a();

    // Store with STORE_LAT=3; events during STALL are ignored.
    bus_a.store = 1'b1;
    settle();
    check_val("st_t_wea", 32'(bus_a.wea), 32'd1);
    check_val("st_t_sel", 32'(bus_a.ram_addr_sel), 32'd1);
    check_val("st_t_en", en_a(), 32'd0);
    step();
    bus_a.store = 1'b0; bus_a.start = 1'b1; bus_a.halt_req = 1'b1; bus_a.branch_taken = 1'b1;
    settle();
    check_val("st_t1_wea", 32'(bus_a.wea), 32'd1);
    check_val("st_t1_en", en_a(), 32'd0);
    check_val("st_t1_flush", fl_a(), 32'd0);
    step();
    settle();
    check_val("st_t2_wea", 32'(bus_a.wea), 32'd1);
    check_val("st_t2_sel", 32'(bus_a.ram_addr_sel), 32'd1);
    check_val("st_t2_en", en_a(), 32'hF);
    check_val("st_t2_flush", fl_a(), 32'd0);
    step();
    clr_a();
    settle();
    check_val("st_t3_wea", 32'(bus_a.wea), 32'd0);
    check_val("st_t3_en", en_a(), 32'hF);
    check_val("st_t3_busy", 32'(bus_a.busy), 32'd1);

    // Taken branch with FLUSH_DEPTH=2 masks the next two cycles.
    bus_a.branch_taken = 1'b1;
    settle();
    check_val("br_flush", fl_a(), 32'd3);
    check_val("br_en", en_a(), 32'hF);
    check_val("br_wea", 32'(bus_a.wea), 32'd0);
    step();
    bus_a.branch_taken = 1'b0; bus_a.store = 1'b1;
    settle();
    check_val("br_f1_wea", 32'(bus_a.wea), 32'd0);
    check_val("br_f1_flush", fl_a(), 32'd0);
    check_val("br_f1_en", en_a(), 32'hF);
    step();
    settle();
    check_val("br_f2_wea", 32'(bus_a.wea), 32'd0);
    step();
    settle();
    check_val("br_run_wea", 32'(bus_a.wea), 32'd1);
    step();
    bus_a.store = 1'b0;
    step();
    step();
    settle();
    check_val("br_back_wea", 32'(bus_a.wea), 32'd0);
    check_val("br_back_en", en_a(), 32'hF);

    // Branch beats store; store beats halt.
    bus_a.branch_taken = 1'b1; bus_a.store = 1'b1;
    settle();
    check_val("bs_flush", fl_a(), 32'd3);
    check_val("bs_wea", 32'(bus_a.wea), 32'd0);
    step();
    bus_a.branch_taken = 1'b0;
    settle();
    check_val("bs_masked_wea", 32'(bus_a.wea), 32'd0);
    bus_a.store = 1'b0;
    step();
    step();
    bus_a.halt_req = 1'b1; bus_a.store = 1'b1;
    settle();
    check_val("hs_wea", 32'(bus_a.wea), 32'd1);
    check_val("hs_en", en_a(), 32'd0);
    step();
    clr_a();
    settle();
    check_val("hs_busy", 32'(bus_a.busy), 32'd1);
    check_val("hs_stall_wea", 32'(bus_a.wea), 32'd1);
    step();
    step();

    // Halt retires, then IDLE ignores store.
    bus_a.halt_req = 1'b1;
    settle();
    check_val("halt_en", en_a(), 32'hF);
    check_val("halt_busy", 32'(bus_a.busy), 32'd1);
    step();
    clr_a();
    settle();
    check_val("halt_idle_busy", 32'(bus_a.busy), 32'd0);
    check_val("halt_idle_en", en_a(), 32'd0);
    bus_a.store = 1'b1;
    settle();
    check_val("idle_store_wea", 32'(bus_a.wea), 32'd0);
    clr_a();

    // Reset in RUN.
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    settle();
    check_val("rr_pre_en", en_a(), 32'hF);
    rst_a = 1'b1;
    step();
    settle();
    check_val("rr_busy", 32'(bus_a.busy), 32'd0);
    check_val("rr_en", en_a(), 32'd0);
    check_val("rr_sel", 32'(bus_a.ram_addr_sel), 32'd0);
    rst_a = 1'b0;

    // Reset mid-store aborts the write.
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0; bus_a.store = 1'b1;
    step();
    bus_a.store = 1'b0;
    settle();
    check_val("rs_pre_wea", 32'(bus_a.wea), 32'd1);
    rst_a = 1'b1;
    step();
    settle();
    check_val("rs_wea", 32'(bus_a.wea), 32'd0);
    check_val("rs_busy", 32'(bus_a.busy), 32'd0);
    rst_a = 1'b0;

    // STORE_LAT=1 / FLUSH_DEPTH=1 boundaries.
    rst_b = 1'b0;
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0; bus_b.store = 1'b1;
    settle();
    check_val("b_st_wea", 32'(bus_b.wea), 32'd1);
    check_val("b_st_sel", 32'(bus_b.ram_addr_sel), 32'd1);
    check_val("b_st_en", en_b(), 32'hF);
    step();
    bus_b.store = 1'b0;
    settle();
    check_val("b_after_wea", 32'(bus_b.wea), 32'd0);
    check_val("b_after_busy", 32'(bus_b.busy), 32'd1);
    check_val("b_after_en", en_b(), 32'hF);
    bus_b.branch_taken = 1'b1;
    settle();
    check_val("b_br_flush", 32'({bus_b.if_id_flush, bus_b.id_ex_flush}), 32'd3);
    step();
    bus_b.branch_taken = 1'b0; bus_b.store = 1'b1;
    settle();
    check_val("b_mask_wea", 32'(bus_b.wea), 32'd0);
    step();
    settle();
    check_val("b_unmask_wea", 32'(bus_b.wea), 32'd1);
    step();
    bus_b.store = 1'b0;
    settle();
    check_val("b_end_en", en_b(), 32'hF);
    check_val("b_end_wea", 32'(bus_b.wea), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central sequencer for the 4-stage CPU pipeline (fetch, decode, execute, writeback).
- Drives per-stage register enables and flush strobes.
- Holds the pipeline for a multi-cycle RAM store and owns the RAM write strobe and RAM address select.
- Masks stale control after a taken branch.
- Produces the execute-stage B-bus mux select, including the forward override.

Parameters:
STORE_LAT, 2, cycles a RAM store occupies (wea high); legal range 1..15
FLUSH_DEPTH, 1, cycles after a taken branch during which execute-stage control inputs are ignored; legal range 1..7
REG_AW, 5, register-index width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  leave IDLE and begin execution
halt_req  in  1  halt instruction in execute
store  in  1  store instruction in execute
branch_taken  in  1  branch resolved taken in execute
src_ex  in  REG_AW  execute-stage source register
dst_wb  in  REG_AW  writeback-stage destination register
wb_valid  in  1  writeback stage holds a register-writing instruction
mode_in  in  2  decoded addressing mode at execute
mode_out  out  2  B-bus mux select
pc_en, if_id_en, id_ex_en, ex_wb_en  out  1 each  stage register enables
if_id_flush, id_ex_flush  out  1 each  load bubble into the stage register
wea  out  1  RAM write enable
ram_addr_sel  out  1  0 = read address, 1 = write address
busy  out  1  state != IDLE

Behaviour:
- States: IDLE=0, RUN=1, STALL=2, FLUSH=3. Counter cnt is 4 bits.
- Stage enables, flushes, wea and ram_addr_sel are decoded combinationally from state, cnt and inputs. State and cnt are registered.
- Reset: state IDLE, cnt 0. All enables, flushes, wea, ram_addr_sel and busy are 0. mode_out stays combinational.
- rst mid-store aborts the write: wea is 0 from the next cycle.
- mode_out:
  - 2'b11 when mode_in==2'b10 and wb_valid and src_ex==dst_wb; otherwise mode_in.
  - This holds in every state. Immediate (00) and direct (01) modes are never overridden.
- IDLE: all enables 0. start=1 → RUN on the next cycle. Other inputs are ignored.
- RUN: all enables 1 by default. Input priority is branch_taken > store > halt_req.
  - branch_taken:
    - In the same cycle: if_id_flush=1, id_ex_flush=1, enables 1 (PC loads target).
    - Next state FLUSH with cnt=FLUSH_DEPTH-1.
  - store:
    - In the same cycle: wea=1, ram_addr_sel=1.
    - STORE_LAT==1: enables stay 1 and the state stays RUN.
    - Otherwise: pc_en, if_id_en, id_ex_en, ex_wb_en = 0; next state STALL with cnt=STORE_LAT-2.
  - halt_req: enables 1 for that cycle so the halt retires; next state IDLE.
- STALL:
  - wea=1 and ram_addr_sel=1 throughout.
  - cnt!=0: enables 0 and cnt decrements.
  - cnt==0: enables 1 so the store advances; next state RUN.
  - store, branch_taken and halt_req are ignored.
  - Net effect: wea is high for exactly STORE_LAT cycles and the pipeline is frozen for STORE_LAT-1 cycles.
- FLUSH:
  - Enables 1, flushes 0, wea 0.
  - store, branch_taken and halt_req are masked because they come from squashed slots.
  - cnt==0 → RUN; otherwise cnt decrements.
  - Net effect: masking lasts exactly FLUSH_DEPTH cycles.
- start outside IDLE is ignored.
- Inputs are sampled only in RUN, so simultaneous events in STALL or FLUSH are ignored.

Decomposition:
- Package pipeline_ctrl_pkg:
  - state enum (IDLE, RUN, STALL, FLUSH);
  - mode constants MODE_IMM=2'b00, MODE_DIR=2'b01, MODE_REG=2'b10, MODE_FWD=2'b11.
- Sub-module fwd_select: the combinational mode_out override, reusable by a future second-operand forward path.

Test Plan:
1. Reset then start pulse → busy=1 and all enables 1 one cycle later. rst=1 in RUN → next cycle all outputs 0, state IDLE.
2. STORE_LAT=3, store=1 in RUN at cycle t:
   - wea=1 and ram_addr_sel=1 at t, t+1, t+2;
   - enables 0 at t and t+1, 1 at t+2;
   - RUN at t+3 with wea=0.
3. branch_taken=1 in RUN, FLUSH_DEPTH=2:
   - if_id_flush=id_ex_flush=1 for one cycle;
   - store=1 held over the next 2 cycles → wea stays 0;
   - store=1 on the 3rd cycle → wea=1.
4. Forward override:
   - mode_in=10, wb_valid=1, src_ex=dst_wb=5'd7 → mode_out=11;
   - same with mode_in=00 → 00;
   - wb_valid=0 → 10.
5. branch_taken=1 and store=1 in the same RUN cycle → flush taken, wea=0, state FLUSH. halt_req=1 with store=1 → store path taken and state stays busy.
6. halt_req in RUN → enables 1 that cycle, then IDLE with all enables 0. start=1 in STALL has no effect. STORE_LAT=1 store → wea a single cycle and no freeze.
